// File: rtl/complex_mul_ctrl.sv
// Control FSM sequencing the four partial products and two sums of a complex
// multiply on one shared multiplier. Optional a*conj(b) mode under CMUL_CONJ_EN.
module complex_mul_ctrl #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef CMUL_CONJ_EN
  input  logic               conj,
`endif
  output logic               busy,
  output logic               done,
  output logic               a_sel,
  output logic               b_sel,
  output logic               pp1_ce,
  output logic               pp2_ce,
  output logic               sub,
  output logic               p_r_ce,
  output logic               p_i_ce,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [8:0]         ctrl_q;
  logic [COUNT_W-1:0] count_q;
  logic               accept;
  logic               conj_op;

  // Control word order: busy, done, a_sel, b_sel, pp1_ce, pp2_ce, sub, p_r_ce, p_i_ce
  function automatic logic [8:0] decode(input state_t s, input logic cj);
    logic [8:0] w;
    w = '0;
    case (s)
      S1:      w = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      S2:      w = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      S3:      w = {1'b1, 1'b0, cj,   ~cj,  1'b1, 1'b0, ~cj,  1'b1, 1'b0};
      S4:      w = {1'b1, 1'b0, ~cj,  cj,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      S5:      w = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cj,   1'b0, 1'b1};
      DONE:    w = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef CMUL_CONJ_EN
  logic conj_q;

  // Mode is frozen at the accept edge so a toggling conj cannot corrupt an operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      conj_q <= 1'b0;
    end else if (accept) begin
      conj_q <= conj;
    end
  end

  assign conj_op = conj_q;
`else
  assign conj_op = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? S1 : IDLE;
      S1:      state_d = S2;
      S2:      state_d = S3;
      S3:      state_d = S4;
      S4:      state_d = S5;
      S5:      state_d = DONE;
      DONE:    state_d = start ? S1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with state_q
  // and the count already shows the new value during the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d, conj_op);
      if (state_d == DONE) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  assign {busy, done, a_sel, b_sel, pp1_ce, pp2_ce, sub, p_r_ce, p_i_ce} = ctrl_q;
  assign op_count = count_q;

endmodule

// File: tb/tb_complex_mul_ctrl.sv
// Directed bench for complex_mul_ctrl: checks the control word per cycle and the
// results of a small Q4.12 datapath model driven by the controller's selects/enables.
module tb_complex_mul_ctrl;

  logic clk = 1'b0;
  logic reset, start, start2;
`ifdef CMUL_CONJ_EN
  logic conj;
`endif

  logic busy, done, a_sel, b_sel, pp1_ce, pp2_ce, sub, p_r_ce, p_i_ce;
  logic [15:0] op_count;
  logic busy2, done2, a_sel2, b_sel2, pp1_ce2, pp2_ce2, sub2, p_r_ce2, p_i_ce2;
  logic [1:0] op_count2;

  logic [8:0] ctrl, ctrl2;
  assign ctrl  = {busy, done, a_sel, b_sel, pp1_ce, pp2_ce, sub, p_r_ce, p_i_ce};
  assign ctrl2 = {busy2, done2, a_sel2, b_sel2, pp1_ce2, pp2_ce2, sub2, p_r_ce2, p_i_ce2};

  localparam logic [8:0] W_IDLE = 9'b000000000;
  localparam logic [8:0] W_S1   = 9'b100010000;
  localparam logic [8:0] W_S2   = 9'b101101000;
  localparam logic [8:0] W_S3   = 9'b100110110;
  localparam logic [8:0] W_S4   = 9'b101001000;
  localparam logic [8:0] W_S5   = 9'b100000001;
  localparam logic [8:0] W_DONE = 9'b010000000;
  localparam logic [8:0] W_S3C  = 9'b101010010;
  localparam logic [8:0] W_S4C  = 9'b100101000;
  localparam logic [8:0] W_S5C  = 9'b100000101;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  complex_mul_ctrl #(.COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef CMUL_CONJ_EN
    .conj(conj),
`endif
    .busy(busy), .done(done), .a_sel(a_sel), .b_sel(b_sel),
    .pp1_ce(pp1_ce), .pp2_ce(pp2_ce), .sub(sub), .p_r_ce(p_r_ce), .p_i_ce(p_i_ce),
    .op_count(op_count)
  );

  complex_mul_ctrl #(.COUNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
`ifdef CMUL_CONJ_EN
    .conj(1'b0),
`endif
    .busy(busy2), .done(done2), .a_sel(a_sel2), .b_sel(b_sel2),
    .pp1_ce(pp1_ce2), .pp2_ce(pp2_ce2), .sub(sub2), .p_r_ce(p_r_ce2), .p_i_ce(p_i_ce2),
    .op_count(op_count2)
  );

  // Datapath model: Q4.12 operands, Q8.24 products and results.
  logic signed [15:0] a_r, a_i, b_r, b_i;
  logic signed [31:0] pp1, pp2, p_r, p_i, mul;
  assign mul = (a_sel ? a_i : a_r) * (b_sel ? b_i : b_r);

  always_ff @(posedge clk) begin
    if (pp1_ce) pp1 <= mul;
    if (pp2_ce) pp2 <= mul;
    if (p_r_ce) p_r <= sub ? (pp1 - pp2) : (pp1 + pp2);
    if (p_i_ce) p_i <= sub ? (pp1 - pp2) : (pp1 + pp2);
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int dones;

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
`ifdef CMUL_CONJ_EN
    conj = 1'b0;
`endif
    a_r = 16'sd6144; a_i = -16'sd8192; b_r = 16'sd1024; b_i = 16'sd12288;
    step(); step();
    reset = 1'b0;
    chk("reset_ctrl", ctrl, W_IDLE);
    chk("reset_count", op_count, 0);

    // Single operation: (1.5 - 2j)*(0.25 + 3j) = 6.375 + 4j
    start = 1'b1;
    step(); start = 1'b0;
    chk("t1_s1", ctrl, W_S1); step();
    chk("t1_s2", ctrl, W_S2); step();
    chk("t1_s3", ctrl, W_S3); step();
    chk("t1_s4", ctrl, W_S4); step();
    chk("t1_s5", ctrl, W_S5); step();
    chk("t1_done_c6", ctrl, W_DONE);
    chk("t1_p_r", p_r, 106954752);
    chk("t1_p_i", p_i, 67108864);
    chk("t1_count", op_count, 1);
    step();
    chk("t1_idle", ctrl, W_IDLE);

    // Start held high: done every 6 cycles, never together with busy
    reset = 1'b1; step(); reset = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      chk($sformatf("t2_done_c%0d", k), done, (k % 6 == 0));
      if (done) chk($sformatf("t2_busy_c%0d", k), busy, 0);
      if (k % 6 == 0) chk($sformatf("t2_p_r_c%0d", k), p_r, 106954752);
    end
    start = 1'b0;
    chk("t2_count", op_count, 3);
    step();
    chk("t2_idle", ctrl, W_IDLE);

    // Extra start pulses in S2 and S4 are ignored
    dones = 0;
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("t3_in_s2", ctrl, W_S2);
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("t3_in_s4", ctrl, W_S4);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done) dones++;
      step();
    end
    chk("t3_dones", dones, 1);
    chk("t3_count", op_count, 4);
    chk("t3_idle", ctrl, W_IDLE);
    chk("t3_p_i", p_i, 67108864);

    // Reset during S3, then a fresh operation: (0.5 + 1j)*(2 - 1j) = 2 + 1.5j
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("t4_in_s3", ctrl, W_S3);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t4_rst_ctrl", ctrl, W_IDLE);
    chk("t4_rst_count", op_count, 0);
    step();
    chk("t4_stay_idle", ctrl, W_IDLE);
    a_r = 16'sd2048; a_i = 16'sd4096; b_r = 16'sd8192; b_i = -16'sd4096;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("t4_done", ctrl, W_DONE);
    chk("t4_p_r", p_r, 33554432);
    chk("t4_p_i", p_i, 25165824);
    chk("t4_count", op_count, 1);
    step();

    // 2-bit counter wraps: 1, 2, 3, 0, 1
    for (int n = 1; n <= 5; n++) begin
      start2 = 1'b1; step(); start2 = 1'b0;
      for (int k = 0; k < 5; k++) step();
      chk($sformatf("t5_done_op%0d", n), ctrl2, W_DONE);
      chk($sformatf("t5_count_op%0d", n), op_count2, n % 4);
      step();
    end

`ifdef CMUL_CONJ_EN
    // a*conj(b) = -5.625 - 5j; conj toggled mid-operation must not matter
    a_r = 16'sd6144; a_i = -16'sd8192; b_r = 16'sd1024; b_i = 16'sd12288;
    conj = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk("t6_s1", ctrl, W_S1);
    conj = 1'b0; step();
    chk("t6_s2", ctrl, W_S2); step();
    chk("t6_s3", ctrl, W_S3C);
    conj = 1'b1; step();
    chk("t6_s4", ctrl, W_S4C);
    conj = 1'b0; step();
    chk("t6_s5", ctrl, W_S5C); step();
    chk("t6_done", ctrl, W_DONE);
    chk("t6_p_r", p_r, -94371840);
    chk("t6_p_i", p_i, -83886080);
    step();
    conj = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("t6_plain_s3", ctrl, W_S3);
    for (int k = 0; k < 3; k++) step();
    chk("t6_plain_p_r", p_r, 106954752);
    chk("t6_plain_p_i", p_i, 67108864);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
